// File: rtl/intc_pkg.sv
// intc_pkg: shared FSM state type, bus codes and vector packing for the interrupt responder
package intc_pkg;
  localparam int NCHAN = 9;
  localparam logic [3:0] CHAN_MAX = 4'd8;
  localparam logic [1:0] BUS_A = 2'd0;
  localparam logic [1:0] BUS_B = 2'd1;
  localparam logic [1:0] BUS_C = 2'd2;
  typedef enum logic [1:0] {IDLE, REQ, ACK, GAP} state_t;
  // the 6-bit vector keeps the low six bits of {bus_code, 0, chan}
  function automatic logic [5:0] vec_f(input logic [1:0] b, input logic [3:0] c);
    logic [6:0] v;
    v = {b, 1'b0, c};
    return v[5:0];
  endfunction
endpackage

// File: rtl/intc_responder_if.sv
// intc_responder_if: controller/CPU side signals of the interrupt responder
interface intc_responder_if;
  import intc_pkg::*;
  logic irq_valid;
  logic [2:0] bus_sel;
  logic [3:0] chan;
  logic cpu_ack;
  logic cpu_done;
  logic irq_to_cpu;
  logic [5:0] vector;
  logic [NCHAN-1:0] ack_a;
  logic [NCHAN-1:0] ack_b;
  logic [NCHAN-1:0] ack_c;
  logic busy;
  logic err;
  modport master(output irq_valid, bus_sel, chan, cpu_ack, cpu_done,
                 input irq_to_cpu, vector, ack_a, ack_b, ack_c, busy, err);
  modport slave(input irq_valid, bus_sel, chan, cpu_ack, cpu_done,
                output irq_to_cpu, vector, ack_a, ack_b, ack_c, busy, err);
endinterface

// File: rtl/intc_onehot_dec.sv
// intc_onehot_dec: bus/channel to 27-bit one-hot, bit index = bus*NCHAN + chan
module intc_onehot_dec
  import intc_pkg::*;
(
  input  logic [1:0]           bus,
  input  logic [3:0]           chan,
  input  logic                 en,
  output logic [3*NCHAN-1:0]   onehot
);
  localparam logic [3*NCHAN-1:0] ONE = 1;
  logic [5:0] idx;
  always_comb begin
    idx = 6'(bus) * 6'(NCHAN) + 6'(chan);
    onehot = en ? ONE << idx : '0;
  end
endmodule

// File: rtl/intc_responder.sv
// intc_responder: captures a granted interrupt, presents it to the CPU and acknowledges the source
module intc_responder
  import intc_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int NCHAN = 9
) (
  input logic clk,
  input logic rst,
  intc_responder_if.slave io
);
  state_t state, state_n;
  logic [1:0] bus_q, bus_n;
  logic [3:0] chan_q, chan_n;
  logic [7:0] cnt, cnt_n;
  logic err_n, legal;
  logic [3*NCHAN-1:0] oh;
  always_comb begin
    state_n = state;
    bus_n = bus_q;
    chan_n = chan_q;
    cnt_n = cnt;
    err_n = 1'b0;
    legal = io.bus_sel != 3'd0 && io.chan < 4'(NCHAN);
    unique case (state)
      IDLE: if (io.irq_valid) begin
        if (legal) begin
          state_n = REQ;
          bus_n = io.bus_sel[0] ? BUS_A : io.bus_sel[1] ? BUS_B : BUS_C;
          chan_n = io.chan;
          cnt_n = 8'd0;
        end else err_n = 1'b1;
      end
      REQ: begin
        // an acknowledge arriving with the timeout still wins
        if (io.cpu_ack) state_n = ACK;
        else if (cnt == 8'(TIMEOUT - 1)) begin
          state_n = IDLE;
          err_n = 1'b1;
        end else cnt_n = cnt + 8'd1;
      end
      ACK: state_n = io.cpu_done ? GAP : ACK;
      GAP: state_n = IDLE;
    endcase
    if (state_n == IDLE) begin
      bus_n = 2'd0;
      chan_n = 4'd0;
      cnt_n = 8'd0;
    end
  end
  intc_onehot_dec dec (.bus(bus_n), .chan(chan_n), .en(state_n == ACK), .onehot(oh));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus_q <= 2'd0;
      chan_q <= 4'd0;
      cnt <= 8'd0;
      io.irq_to_cpu <= 1'b0;
      io.busy <= 1'b0;
      io.err <= 1'b0;
      io.vector <= 6'd0;
      io.ack_a <= '0;
      io.ack_b <= '0;
      io.ack_c <= '0;
    end else begin
      state <= state_n;
      bus_q <= bus_n;
      chan_q <= chan_n;
      cnt <= cnt_n;
      io.irq_to_cpu <= state_n == REQ;
      io.busy <= state_n == ACK;
      io.err <= err_n;
      io.vector <= (state_n == REQ || state_n == ACK) ? vec_f(bus_n, chan_n) : 6'd0;
      io.ack_a <= oh[NCHAN-1:0];
      io.ack_b <= oh[2*NCHAN-1:NCHAN];
      io.ack_c <= oh[3*NCHAN-1:2*NCHAN];
    end
  end
endmodule
